// File: rtl/psum_pkg.sv
// ---------------------------------------------------------------------------
// psum_pkg
// Constants and types shared between PSUM_BUFF and its output drain.
//   - PSUM_DATA_WIDTH / PSUM_OUT_WIDTH / PSUM_PACK : stream and packing widths
//   - OUT_MAX / OUT_MIN                            : signed 8-bit saturation limits
//   - state_t + ST_* constants                     : drain FSM encoding
// No ports (package).
// ---------------------------------------------------------------------------
package psum_pkg;

    localparam int PSUM_DATA_WIDTH = 25;
    localparam int PSUM_OUT_WIDTH  = 8;
    localparam int PSUM_PACK       = 4;

    localparam int OUT_MAX = 127;
    localparam int OUT_MIN = -128;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/psum_drain_fifo.sv
// ---------------------------------------------------------------------------
// psum_drain_fifo
// Small synchronous word queue sitting between the lane packer and the SRAM
// write port. Pointers carry one extra wrap bit so full and empty can be told
// apart when the low bits match.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (clears pointers)
//   i_push       : write i_push_data (taken if not full, or full with a pop)
//   i_push_data  : word to enqueue
//   i_pop        : remove head (ignored when empty)
//   o_full       : QDEPTH words stored
//   o_empty      : no words stored
//   o_head       : oldest word, forced to 0 when empty
// ---------------------------------------------------------------------------
module psum_drain_fifo
    import psum_pkg::*;
#(
    parameter int WIDTH       = PSUM_PACK * PSUM_OUT_WIDTH,
    parameter int QDEPTH      = 4,
    parameter int QADDR_WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0]     r_mem [QDEPTH];
    logic [QADDR_WIDTH:0] r_wr_ptr;
    logic [QADDR_WIDTH:0] r_rd_ptr;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[QADDR_WIDTH] != r_rd_ptr[QADDR_WIDTH]) &&
                     (r_wr_ptr[QADDR_WIDTH-1:0] == r_rd_ptr[QADDR_WIDTH-1:0]);

    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full queue is fine when the head leaves on the same edge.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Head reads zero when empty so the write-data port is clean after reset.
    assign o_head = o_empty ? '0 : r_mem[r_rd_ptr[QADDR_WIDTH-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[QADDR_WIDTH-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/psum_drain.sv
// ---------------------------------------------------------------------------
// psum_drain
// Drains the PSUM_BUFF stream: each psum is rounded, arithmetically shifted
// and saturated to signed 8 bits, four results are packed into a 32-bit word
// (lane0 in bits [7:0]) and words are written to the output feature-map SRAM
// at consecutive addresses. A small queue absorbs SRAM stalls because the
// psum stream cannot be held off.
//
// Optional build macro: PSUM_DRAIN_RELU_EN -- clamps negative results to 0.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : pulse in IDLE, latches cfg_* and begins a drain
//   cfg_shift       : right-shift amount (0..24)
//   cfg_base_addr   : first SRAM word address
//   cfg_num_words   : number of words in this drain
//   valid_fifo_out  : psum strobe
//   fifo_out        : signed psum
//   wr_en/wr_ready  : SRAM write handshake
//   wr_addr/wr_data : SRAM write address / packed word
//   busy            : drain in progress
//   done            : one-cycle pulse after the final word retires
//   overflow        : sticky, a word was dropped on a full queue
// ---------------------------------------------------------------------------
module psum_drain
    import psum_pkg::*;
#(
    parameter int DATA_WIDTH  = PSUM_DATA_WIDTH,
    parameter int OUT_WIDTH   = PSUM_OUT_WIDTH,
    parameter int PACK        = PSUM_PACK,
    parameter int SHIFT_WIDTH = 5,
    parameter int QDEPTH      = 4,
    parameter int QADDR_WIDTH = 2,
    parameter int ADDR_WIDTH  = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [SHIFT_WIDTH-1:0]    cfg_shift,
    input  logic [ADDR_WIDTH-1:0]     cfg_base_addr,
    input  logic [ADDR_WIDTH-1:0]     cfg_num_words,
    input  logic                      valid_fifo_out,
    input  logic [DATA_WIDTH-1:0]     fifo_out,
    output logic                      wr_en,
    input  logic                      wr_ready,
    output logic [ADDR_WIDTH-1:0]     wr_addr,
    output logic [PACK*OUT_WIDTH-1:0] wr_data,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow
);

    localparam int WORD_W = PACK * OUT_WIDTH;
    localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;

    localparam logic signed [DATA_WIDTH:0] SAT_MAX = (DATA_WIDTH+1)'(OUT_MAX);
    localparam logic signed [DATA_WIDTH:0] SAT_MIN = (DATA_WIDTH+1)'(OUT_MIN);

    // Round-half-up then arithmetic shift, one bit wider than the input so
    // adding the rounding bias can never wrap.
    function automatic logic signed [DATA_WIDTH:0] round_shift(
        input logic signed [DATA_WIDTH-1:0] x,
        input logic [SHIFT_WIDTH-1:0]       sh
    );
        logic signed [DATA_WIDTH:0] bias;
        logic signed [DATA_WIDTH:0] sum;
        bias = '0;
        if (sh != '0) bias[sh - 1'b1] = 1'b1;
        sum = $signed({x[DATA_WIDTH-1], x}) + bias;
        return sum >>> sh;
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] saturate(
        input logic signed [DATA_WIDTH:0] v
    );
        if (v > SAT_MAX)      return SAT_MAX[OUT_WIDTH-1:0];
        else if (v < SAT_MIN) return SAT_MIN[OUT_WIDTH-1:0];
        else                  return v[OUT_WIDTH-1:0];
    endfunction

    state_t                       r_state;
    logic [SHIFT_WIDTH-1:0]       r_shift;
    logic [ADDR_WIDTH-1:0]        r_num_words;
    logic [ADDR_WIDTH-1:0]        r_wr_addr;
    logic                         r_overflow;
    logic [LANE_W-1:0]            r_lane_cnt;
    logic [ADDR_WIDTH-1:0]        r_push_cnt;
    logic [ADDR_WIDTH-1:0]        r_ret_cnt;
    logic                         r_vld_p1;
    logic signed [OUT_WIDTH-1:0]  r_q_p1;
    logic [WORD_W-1:0]            r_word_p2;

    logic                         w_run;
    logic                         w_push_open;
    logic                         w_s1_vld;
    logic signed [OUT_WIDTH-1:0]  w_q_p0;
    logic                         w_s2_vld;
    logic                         w_lane_last;
    logic [WORD_W-1:0]            w_word;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_drop;
    logic                         w_retire;
    logic [ADDR_WIDTH-1:0]        w_ret_next;
    logic                         w_full;
    logic                         w_empty;
    logic [WORD_W-1:0]            w_head;

    assign w_run       = (r_state == ST_RUN);
    // Once the requested number of words has been pushed, further psums
    // (and any partially filled lanes) are discarded.
    assign w_push_open = w_run && (r_push_cnt != r_num_words);

    // ---- stage 0 -> 1: requantize ----
    assign w_s1_vld = valid_fifo_out && w_push_open;

    always_comb begin
        w_q_p0 = saturate(round_shift($signed(fifo_out), r_shift));
`ifdef PSUM_DRAIN_RELU_EN
        if (w_q_p0 < 0) w_q_p0 = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (w_s1_vld) r_q_p1 <= w_q_p0;
    end

    // ---- stage 1 -> 2: lane packing and queue push ----
    assign w_s2_vld    = r_vld_p1 && w_push_open;
    assign w_lane_last = (r_lane_cnt == LANE_W'(PACK - 1));

    always_comb begin
        w_word = r_word_p2;
        w_word[int'(r_lane_cnt)*OUT_WIDTH +: OUT_WIDTH] = r_q_p1;
    end

    always_ff @(posedge clk) begin
        if (w_s2_vld) r_word_p2 <= w_word;
    end

    assign w_push = w_s2_vld && w_lane_last;
    assign w_pop  = wr_en && wr_ready;
    assign w_drop = w_push && w_full && !w_pop;

    // Dropped words retire just like written ones so the drain still ends.
    assign w_retire   = w_pop || w_drop;
    assign w_ret_next = r_ret_cnt + {{(ADDR_WIDTH-1){1'b0}}, w_retire};

    psum_drain_fifo #(
        .WIDTH       (WORD_W),
        .QDEPTH      (QDEPTH),
        .QADDR_WIDTH (QADDR_WIDTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_word),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head      (w_head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_num_words <= '0;
            r_wr_addr   <= '0;
            r_overflow  <= 1'b0;
            r_lane_cnt  <= '0;
            r_push_cnt  <= '0;
            r_ret_cnt   <= '0;
            r_vld_p1    <= 1'b0;
        end else begin
            r_vld_p1  <= w_s1_vld;
            r_ret_cnt <= w_ret_next;
            if (w_pop)    r_wr_addr  <= r_wr_addr + 1'b1;
            if (w_s2_vld) r_lane_cnt <= w_lane_last ? '0 : r_lane_cnt + 1'b1;
            if (w_push)   r_push_cnt <= r_push_cnt + 1'b1;
            if (w_drop)   r_overflow <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_shift     <= cfg_shift;
                        r_num_words <= cfg_num_words;
                        r_wr_addr   <= cfg_base_addr;
                        r_overflow  <= 1'b0;
                        r_lane_cnt  <= '0;
                        r_push_cnt  <= '0;
                        r_ret_cnt   <= '0;
                        r_state     <= (cfg_num_words == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_retire && (w_ret_next == r_num_words)) r_state <= ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wr_en    = !w_empty;
    assign wr_data  = w_head;
    assign wr_addr  = r_wr_addr;
    assign busy     = w_run;
    assign done     = (r_state == ST_DONE);
    assign overflow = r_overflow;

endmodule

// File: tb/tb_psum_drain.sv
// ---------------------------------------------------------------------------
// tb_psum_drain
// Directed bench for psum_drain: reset values, requantization, packing,
// latency, address wrap, stall/overflow, zero-length drain and async reset.
// ---------------------------------------------------------------------------
module tb_psum_drain;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  cfg_shift;
    logic [9:0]  cfg_base_addr;
    logic [9:0]  cfg_num_words;
    logic        valid_fifo_out;
    logic [24:0] fifo_out;
    logic        wr_en;
    logic        wr_ready;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        overflow;

    int n_chk = 0;
    int n_err = 0;
    int nw;
    bit done_seen;
    logic [9:0] mon_base;

    psum_drain dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .cfg_shift      (cfg_shift),
        .cfg_base_addr  (cfg_base_addr),
        .cfg_num_words  (cfg_num_words),
        .valid_fifo_out (valid_fifo_out),
        .fifo_out       (fifo_out),
        .wr_en          (wr_en),
        .wr_ready       (wr_ready),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [4:0] sh, input logic [9:0] base, input logic [9:0] num);
        start         = 1'b1;
        cfg_shift     = sh;
        cfg_base_addr = base;
        cfg_num_words = num;
        tick();
        start = 1'b0;
    endtask

    task automatic psum(input int v);
        valid_fifo_out = 1'b1;
        fifo_out       = 25'(v);
        tick();
        valid_fifo_out = 1'b0;
    endtask

    // Word n of a stream whose psums are 0,1,2,... with shift 0.
    function automatic logic [31:0] word_of(input int n);
        return {8'(4*n+3), 8'(4*n+2), 8'(4*n+1), 8'(4*n)};
    endfunction

    task automatic mon();
        if (wr_en && wr_ready) begin
            chk("stream_addr", 32'(wr_addr), 32'(10'(mon_base + 10'(nw))));
            chk("stream_data", wr_data, word_of(nw));
            nw++;
        end
        if (done) done_seen = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_t1;
        rst_n = 1'b0; start = 1'b0; cfg_shift = '0; cfg_base_addr = '0;
        cfg_num_words = '0; valid_fifo_out = 1'b0; fifo_out = '0; wr_ready = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_wr_en",    32'(wr_en),    32'd0);
        chk("rst_wr_addr",  32'(wr_addr),  32'd0);
        chk("rst_wr_data",  wr_data,       32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        wr_ready = 1'b1;
        tick();

        // Rounding / saturation, single word
`ifdef PSUM_DRAIN_RELU_EN
        exp_t1 = 32'h007F0003;
`else
        exp_t1 = 32'h807FFD03;
`endif
        do_start(5'd2, 10'd5, 10'd1);
        chk("t1_busy",  32'(busy),    32'd1);
        chk("t1_addr0", 32'(wr_addr), 32'd5);
        psum(13); psum(-13); psum(1000); psum(-1000);
        chk("t1_wr_en_early", 32'(wr_en), 32'd0);
        tick();
        chk("t1_wr_en",   32'(wr_en),   32'd1);
        chk("t1_wr_addr", 32'(wr_addr), 32'd5);
        chk("t1_wr_data", wr_data,      exp_t1);
        tick();
        chk("t1_done",       32'(done),    32'd1);
        chk("t1_wr_en_off",  32'(wr_en),   32'd0);
        chk("t1_addr_inc",   32'(wr_addr), 32'd6);
        chk("t1_busy_off",   32'(busy),    32'd0);
        tick();
        chk("t1_done_pulse", 32'(done),    32'd0);

        // Shift 0, back-to-back, latency
        do_start(5'd0, 10'd0, 10'd1);
        psum(1); psum(2); psum(3); psum(4);
        chk("t2_wr_en_lat1", 32'(wr_en), 32'd0);
        tick();
        chk("t2_wr_en_lat2", 32'(wr_en), 32'd1);
        chk("t2_wr_data",    wr_data,    32'h04030201);
        tick(); tick();

        // Address wrap, continuous stream
        nw = 0; done_seen = 1'b0; mon_base = 10'd1020;
        do_start(5'd0, 10'd1020, 10'd8);
        for (int i = 0; i < 32; i++) begin
            valid_fifo_out = 1'b1;
            fifo_out = 25'(i);
            tick();
            mon();
        end
        valid_fifo_out = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            mon();
        end
        chk("t3_num_writes", 32'(nw),        32'd8);
        chk("t3_done_seen",  32'(done_seen), 32'd1);
        chk("t3_overflow",   32'(overflow),  32'd0);
        chk("t3_final_addr", 32'(wr_addr),   32'd4);

        // Stall, queue overflow, recovery
        nw = 0; done_seen = 1'b0; mon_base = 10'd100;
        wr_ready = 1'b0;
        do_start(5'd0, 10'd100, 10'd6);
        for (int i = 0; i < 24; i++) begin
            valid_fifo_out = 1'b1;
            fifo_out = 25'(i);
            tick();
            mon();
        end
        valid_fifo_out = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("t4_wr_en_stall",  32'(wr_en),    32'd1);
        chk("t4_data_stable",  wr_data,       word_of(0));
        chk("t4_addr_stable",  32'(wr_addr),  32'd100);
        chk("t4_overflow",     32'(overflow), 32'd1);
        chk("t4_busy_stall",   32'(busy),     32'd1);
        wr_ready = 1'b1;
        mon();
        for (int i = 0; i < 10; i++) begin
            tick();
            mon();
        end
        chk("t4_num_writes",  32'(nw),        32'd4);
        chk("t4_done_seen",   32'(done_seen), 32'd1);
        chk("t4_ovf_sticky",  32'(overflow),  32'd1);

        // Zero-length drain; start also clears overflow
        do_start(5'd0, 10'd7, 10'd0);
        chk("t5_done",      32'(done),     32'd1);
        chk("t5_ovf_clear", 32'(overflow), 32'd0);
        chk("t5_wr_en",     32'(wr_en),    32'd0);
        chk("t5_busy",      32'(busy),     32'd0);
        tick();
        chk("t5_done_pulse", 32'(done),    32'd0);
        chk("t5_wr_en_idle", 32'(wr_en),   32'd0);

        // Asynchronous reset mid-drain
        wr_ready = 1'b0;
        do_start(5'd0, 10'd0, 10'd4);
        for (int i = 0; i < 8; i++) psum(i);
        tick();
        chk("t6_wr_en_pre", 32'(wr_en), 32'd1);
        chk("t6_busy_pre",  32'(busy),  32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_wr_en_rst",  32'(wr_en),   32'd0);
        chk("t6_busy_rst",   32'(busy),    32'd0);
        chk("t6_wr_addr_rst",32'(wr_addr), 32'd0);
        #1 rst_n = 1'b1;
        wr_ready = 1'b1;
        for (int i = 0; i < 8; i++) psum(i);
        tick(); tick(); tick();
        chk("t6_wr_en_post", 32'(wr_en),   32'd0);
        chk("t6_busy_post",  32'(busy),    32'd0);
        chk("t6_done_post",  32'(done),    32'd0);
        chk("t6_addr_post",  32'(wr_addr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
